// File: rtl/calc_pkg.sv
// Shared constants for the big-integer serial divider.
//   DIVIDEND_W_DEF / DIVISOR_W_DEF : default operand widths
//   ST_IDLE / ST_RUN / ST_DONE     : FSM state encodings
//   cnt_width()                    : width of the iteration down-counter
package calc_pkg;

   localparam int DIVIDEND_W_DEF = 2048;
   localparam int DIVISOR_W_DEF  = 1024;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Counter runs from n-1 down to 0, so log2(n) bits suffice.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step (combinational).
//   r      : partial remainder, always < d
//   d      : divisor
//   bit_in : next dividend bit shifted into the remainder
//   r_next : partial remainder after the conditional subtract
//   q_bit  : quotient bit produced by this step
// The shifted value T is DIVISOR_W+1 bits wide. Because r < d on entry,
// the result is always < d, so r_next fits in DIVISOR_W bits and the
// subtract only needs to be done on the low bits (modulo arithmetic).
module div_step
   import calc_pkg::*;
#(
   parameter int DIVISOR_W = DIVISOR_W_DEF
) (
   input  logic [DIVISOR_W-1:0] r,
   input  logic [DIVISOR_W-1:0] d,
   input  logic                 bit_in,
   output logic [DIVISOR_W-1:0] r_next,
   output logic                 q_bit
);

   logic [DIVISOR_W:0] t;

   assign t      = {r, bit_in};
   assign q_bit  = (t >= {1'b0, d});
   assign r_next = q_bit ? (t[DIVISOR_W-1:0] - d) : t[DIVISOR_W-1:0];

endmodule

// File: rtl/bigint_serial_divider.sv
// Sequential restoring divider: DIVIDEND_W-bit dividend by DIVISOR_W-bit
// divisor, one quotient bit per clock, start/busy/done handshake.
//   clk, rstn  : clock, async active-low reset
//   Start      : request, accepted in IDLE or DONE
//   Dividend   : numerator, captured on accepted Start
//   Divisor    : denominator, captured on accepted Start
//   Busy       : high while iterating
//   Done       : high while Quot/Rem are valid
//   DivZero    : high with Done when the divisor was zero
//   Quot, Rem  : quotient and remainder (registered)
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | after reset, waiting for Start
// RUN     | shifting/subtracting, one quotient bit per cycle
// DONE    | results valid and held, Start begins a new op
module bigint_serial_divider
   import calc_pkg::*;
#(
   parameter int DIVIDEND_W = DIVIDEND_W_DEF,
   parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  Start,
   input  logic [DIVIDEND_W-1:0] Dividend,
   input  logic [DIVISOR_W-1:0]  Divisor,
   output logic                  Busy,
   output logic                  Done,
   output logic                  DivZero,
   output logic [DIVIDEND_W-1:0] Quot,
   output logic [DIVISOR_W-1:0]  Rem
);

   localparam int              CNT_W    = cnt_width(DIVIDEND_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);

   logic [1:0]            state;
   logic [DIVIDEND_W-1:0] q;
   logic [DIVISOR_W-1:0]  r;
   logic [DIVISOR_W-1:0]  d;
   logic [DIVISOR_W-1:0]  r_next;
   logic                  q_bit;
   logic [CNT_W-1:0]      count;
   logic                  busy;
   logic                  done;
   logic                  div_zero;

   div_step #(
      .DIVISOR_W (DIVISOR_W)
   ) u_step (
      .r      (r),
      .d      (d),
      .bit_in (q[DIVIDEND_W-1]),
      .r_next (r_next),
      .q_bit  (q_bit)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= ST_IDLE;
         q        <= '0;
         r        <= '0;
         d        <= '0;
         count    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               q <= {q[DIVIDEND_W-2:0], q_bit};
               r <= r_next;
               if (count == '0) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  count <= count - 1'b1;
               end
            end
            ST_IDLE, ST_DONE: begin
               if (Start) begin
                  d        <= Divisor;
                  r        <= '0;
                  if (Divisor == '0) begin
                     // Quotient register doubles as the output, so the
                     // all-ones divide-by-zero result is loaded directly.
                     q        <= '1;
                     state    <= ST_DONE;
                     done     <= 1'b1;
                     div_zero <= 1'b1;
                  end else begin
                     q        <= Dividend;
                     count    <= CNT_LAST;
                     state    <= ST_RUN;
                     busy     <= 1'b1;
                     done     <= 1'b0;
                     div_zero <= 1'b0;
                  end
               end
            end
            default: begin
               state    <= ST_IDLE;
               busy     <= 1'b0;
               done     <= 1'b0;
               div_zero <= 1'b0;
            end
         endcase
      end
   end

   assign Busy    = busy;
   assign Done    = done;
   assign DivZero = div_zero;
   assign Quot    = q;
   assign Rem     = r;

endmodule
